// File: rtl/mem_lsu.sv
// Load/store unit between EX/MEM and MEM/WB. It handles one data-memory access at a time, with a bounded ack wait.
// ALU-only and malformed requests complete in one cycle without touching memory.
module mem_lsu #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    funct3,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    wb_in,
  output logic          dm_req,
  output logic          dm_we,
  output logic [3:0]    dm_be,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic          dm_ack,
  input  logic [DW-1:0] dm_rdata,
  output logic          out_valid,
  output logic [1:0]    wb_out,
  output logic [DW-1:0] addr_out,
  output logic [DW-1:0] rdata_out,
  output logic          err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cnt;
  logic [2:0]    f3_q;
  logic [DW-1:0] addr_q;
  logic [1:0]    wb_q;

  logic          is_mem, bad, f3_ok, accept, tmo;
  logic [3:0]    be_c;
  logic [DW-1:0] wdata_c, lane, load_c;

  assign is_mem = mem_read | mem_write;
  assign f3_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign bad    = is_mem & ((mem_read & mem_write) | !f3_ok | (mem_write & funct3[2]) |
                            ((funct3[1:0] == 2'b01) & addr[0]) |
                            ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
  assign tmo    = !dm_ack && (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {(DW/8){wdata[7:0]}};
      end
      2'b01: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {(DW/16){wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection uses the captured address, because the request inputs have moved on by the time the ack arrives.
  assign lane = dm_rdata >> {addr_q[1:0], 3'b000};
  always_comb begin
    load_c = dm_rdata;
    case (f3_q)
      3'b000:  load_c = {{(DW-8){lane[7]}}, lane[7:0]};
      3'b100:  load_c = {{(DW-8){1'b0}}, lane[7:0]};
      3'b001:  load_c = {{(DW-16){lane[15]}}, lane[15:0]};
      3'b101:  load_c = {{(DW-16){1'b0}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid && is_mem && !bad) state_nxt = WAIT;
      end
      WAIT: if (dm_ack || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      f3_q      <= '0;
      addr_q    <= '0;
      wb_q      <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_be     <= '0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      out_valid <= 1'b0;
      wb_out    <= '0;
      addr_out  <= '0;
      rdata_out <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (!is_mem || bad) begin
          out_valid <= 1'b1;
          wb_out    <= bad ? 2'b00 : wb_in;
          addr_out  <= addr;
          rdata_out <= '0;
          err       <= bad;
        end else begin
          dm_req   <= 1'b1;
          dm_we    <= mem_write;
          dm_be    <= be_c;
          dm_addr  <= {addr[DW-1:2], 2'b00};
          dm_wdata <= wdata_c;
          f3_q     <= funct3;
          addr_q   <= addr;
          wb_q     <= wb_in;
          cnt      <= '0;
        end
      end else if (state == WAIT) begin
        // An ack wins over an expiring timeout in the same cycle.
        if (dm_ack || tmo) begin
          dm_req    <= 1'b0;
          out_valid <= 1'b1;
          wb_out    <= dm_ack ? wb_q : 2'b00;
          addr_out  <= addr_q;
          rdata_out <= (dm_ack && !dm_we) ? load_c : '0;
          err       <= !dm_ack;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with TIMEOUT=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0, dm_rdata = '0;
  logic [1:0]  wb_in = '0;
  logic        dm_ack = 1'b0;
  logic        req_ready, dm_req, dm_we, out_valid, err;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, addr_out, rdata_out;
  logic [1:0]  wb_out;

  int n_cmp = 0, n_bad = 0;
  int lat, req_cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  mem_lsu #(.DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
    .wdata(wdata), .wb_in(wb_in), .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .wb_out(wb_out), .addr_out(addr_out),
    .rdata_out(rdata_out), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wb);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    addr = a; wdata = wd; wb_in = wb;
  endtask

  // Single-cycle op: ALU pass-through or rejected access.
  task automatic imm_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] wb, input logic exp_err);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    drive(rd, wr, f3, a, 32'h0, wb);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".ov"},    32'(out_valid), 32'd1);
    chk({tag, ".err"},   32'(err), 32'(exp_err));
    chk({tag, ".wb"},    32'(wb_out), exp_err ? 32'd0 : 32'(wb));
    chk({tag, ".addr"},  addr_out, a);
    chk({tag, ".rdata"}, rdata_out, 32'h0);
    chk({tag, ".dmreq"}, 32'(dm_req), 32'd0);
  endtask

  // Memory op: ack is raised in the wait cycle numbered ack_at (0 = never).
  task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wb,
                        input int ack_at);
    drive(rd, wr, f3, a, wd, wb);
    lat = 0; req_cnt = 0;
    while (lat < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (dm_req) req_cnt++;
      if (lat == 1) begin
        cap_addr = dm_addr; cap_wdata = dm_wdata; cap_be = dm_be; cap_we = dm_we;
      end
      if (out_valid) break;
      dm_ack = (lat == ack_at);
    end
    dm_ack = 1'b0;
    if (!out_valid) chk("mem.timeout_bound", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.outs", {dm_req, dm_we, dm_be, out_valid, err, wb_out}, 32'h0);
    chk("rst.bus", dm_addr | dm_wdata | addr_out | rdata_out, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // LB 0x1003, three ack-less wait cycles then ack (also ack coinciding with the last timeout cycle)
    dm_rdata = 32'h80FF_FFFF;
    mem_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 2'b11, 4);
    chk("lb.be", 32'(cap_be), 32'h8);
    chk("lb.addr", cap_addr, 32'h0000_1000);
    chk("lb.we", 32'(cap_we), 32'd0);
    chk("lb.lat", 32'(lat), 32'd5);
    chk("lb.reqcnt", 32'(req_cnt), 32'd4);
    chk("lb.rdata", rdata_out, 32'hFFFF_FF80);
    chk("lb.err", 32'(err), 32'd0);
    chk("lb.wb", 32'(wb_out), 32'd3);
    chk("lb.addr_out", addr_out, 32'h0000_1003);

    // SH 0x2002
    mem_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 2'b00, 1);
    chk("sh.addr", cap_addr, 32'h0000_2000);
    chk("sh.be", 32'(cap_be), 32'hC);
    chk("sh.wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh.we", 32'(cap_we), 32'd1);
    chk("sh.lat", 32'(lat), 32'd2);
    chk("sh.rdata", rdata_out, 32'h0);

    // SB 0x0001
    mem_op(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 2'b00, 2);
    chk("sb.be", 32'(cap_be), 32'h2);
    chk("sb.wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("sb.lat", 32'(lat), 32'd3);

    // LBU lane 1, LH upper half, LW
    dm_rdata = 32'h1234_56F0;
    mem_op(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 2'b10, 1);
    chk("lbu.rdata", rdata_out, 32'h0000_0056);
    dm_rdata = 32'h8001_0000;
    mem_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 2'b10, 1);
    chk("lh.be", 32'(cap_be), 32'hC);
    chk("lh.rdata", rdata_out, 32'hFFFF_8001);
    dm_rdata = 32'hDEAD_BEEF;
    mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 2'b11, 1);
    chk("lw.be", 32'(cap_be), 32'hF);
    chk("lw.rdata", rdata_out, 32'hDEAD_BEEF);

    // Timeout: no ack ever
    mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 2'b11, 0);
    chk("to.reqcnt", 32'(req_cnt), 32'd4);
    chk("to.lat", 32'(lat), 32'd5);
    chk("to.err", 32'(err), 32'd1);
    chk("to.wb", 32'(wb_out), 32'd0);
    chk("to.dmreq", 32'(dm_req), 32'd0);

    // Rejected accesses
    imm_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_3001, 2'b11, 1'b1);
    imm_op("lh_odd", 1'b1, 1'b0, 3'b001, 32'h0000_3001, 2'b11, 1'b1);
    imm_op("f3_bad", 1'b1, 1'b0, 3'b011, 32'h0000_3000, 2'b11, 1'b1);
    imm_op("sbu",    1'b0, 1'b1, 3'b100, 32'h0000_3000, 2'b00, 1'b1);
    imm_op("rw",     1'b1, 1'b1, 3'b010, 32'h0000_3000, 2'b11, 1'b1);

    // Three back-to-back ALU ops, then a hold check
    imm_op("alu0", 1'b0, 1'b0, 3'b111, 32'h0000_0A00, 2'b10, 1'b0);
    imm_op("alu1", 1'b0, 1'b0, 3'b011, 32'h0000_0A04, 2'b10, 1'b0);
    imm_op("alu2", 1'b0, 1'b0, 3'b000, 32'h0000_0A08, 2'b11, 1'b0);
    @(negedge clk);
    chk("hold.ov", 32'(out_valid), 32'd0);
    chk("hold.addr", addr_out, 32'h0000_0A08);
    chk("hold.wb", 32'(wb_out), 32'd3);

    // Reset while waiting
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 2'b11);
    @(negedge clk); req_valid = 1'b0;
    chk("rw.dmreq_pre", 32'(dm_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw.dmreq_rst", 32'(dm_req), 32'd0);
    chk("rw.ready_rst", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rw.ov_rst", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw.ov_after", 32'(out_valid), 32'd0);
    dm_rdata = 32'h0000_F00F;
    mem_op(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'h0, 2'b11, 1);
    chk("lhu.be", 32'(cap_be), 32'h3);
    chk("lhu.rdata", rdata_out, 32'h0000_F00F);
    chk("lhu.lat", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
